// File: rtl/mixed_width_tdp_ram_be.sv
`default_nettype none
// ============================================================================
// Module  : mixed_width_tdp_ram_be
// Brief   : Single-clock true dual-port RAM, narrow port A / wide port B, with
//           byte enables, optional output register and collision counter.
// Revision: 1.0
// ============================================================================
module mixed_width_tdp_ram_be #(
    parameter int    DATA_WIDTH_A = 8,
    parameter int    ADDR_WIDTH_A = 10,
    parameter int    ADDR_WIDTH_B = 8,
    parameter int    OUT_REG      = 0,
    parameter int    RDW_MODE     = 0,
    parameter string INIT_FILE    = "",
    localparam int   RATIO        = 1 << (ADDR_WIDTH_A - ADDR_WIDTH_B),
    localparam int   DATA_WIDTH_B = DATA_WIDTH_A * RATIO,
    localparam int   BE_A         = DATA_WIDTH_A / 8,
    localparam int   BE_B         = DATA_WIDTH_B / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_en,
    input  logic                    a_we,
    input  logic [BE_A-1:0]         a_be,
    input  logic [ADDR_WIDTH_A-1:0] a_addr,
    input  logic [DATA_WIDTH_A-1:0] a_wdata,
    output logic [DATA_WIDTH_A-1:0] a_rdata,
    output logic                    a_rvalid,
    input  logic                    b_en,
    input  logic                    b_we,
    input  logic [BE_B-1:0]         b_be,
    input  logic [ADDR_WIDTH_B-1:0] b_addr,
    input  logic [DATA_WIDTH_B-1:0] b_wdata,
    output logic [DATA_WIDTH_B-1:0] b_rdata,
    output logic                    b_rvalid,
    output logic                    coll,
    output logic [15:0]             coll_cnt
);

    localparam int c_shift  = ADDR_WIDTH_A - ADDR_WIDTH_B;
    localparam int c_lane_w = (c_shift > 0) ? c_shift : 1;
    localparam int c_depth  = 1 << ADDR_WIDTH_B;

    logic [DATA_WIDTH_B-1:0] r_mem [c_depth];

    logic [ADDR_WIDTH_B-1:0] w_a_word;
    logic [c_lane_w-1:0]     w_a_lane;
    logic [BE_B-1:0]         w_a_lane_mask;
    logic [BE_B-1:0]         w_a_be_wide;
    logic [BE_B-1:0]         w_a_wr_bytes;
    logic [BE_B-1:0]         w_b_wr_bytes;
    logic [DATA_WIDTH_B-1:0] w_a_wdata_wide;
    logic [DATA_WIDTH_B-1:0] w_a_old;
    logic [DATA_WIDTH_B-1:0] w_b_old;
    logic [DATA_WIDTH_B-1:0] w_a_rd_word;
    logic [DATA_WIDTH_B-1:0] w_b_rd_word;
    logic [DATA_WIDTH_A-1:0] w_a_rd;
    logic                    w_same_word;
    logic                    w_a_wr_any;
    logic                    w_b_wr_any;
    logic                    w_coll;

    assign w_a_word = a_addr[ADDR_WIDTH_A-1:c_shift];

    generate
        if (c_shift > 0) begin : g_lane
            assign w_a_lane = a_addr[c_lane_w-1:0];
        end else begin : g_no_lane
            assign w_a_lane = '0;
        end
    endgenerate

    // Place port A's lane and byte enables into wide-word byte positions
    always_comb begin
        w_a_lane_mask = '0;
        w_a_be_wide   = '0;
        for (int l = 0; l < RATIO; l++) begin
            if (w_a_lane == c_lane_w'(l)) begin
                w_a_lane_mask[l*BE_A +: BE_A] = '1;
                w_a_be_wide[l*BE_A +: BE_A]   = a_be;
            end
        end
    end

    assign w_a_wdata_wide = {RATIO{a_wdata}};
    assign w_a_wr_bytes   = {BE_B{a_en & a_we}} & w_a_be_wide;
    assign w_b_wr_bytes   = {BE_B{b_en & b_we}} & b_be;
    assign w_a_old        = r_mem[w_a_word];
    assign w_b_old        = r_mem[b_addr];

    // Each port only ever sees its own writes; the other port's bytes read old
    always_comb begin
        w_a_rd_word = w_a_old;
        w_b_rd_word = w_b_old;
        if (RDW_MODE != 0) begin
            for (int j = 0; j < BE_B; j++) begin
                if (w_a_wr_bytes[j]) w_a_rd_word[j*8 +: 8] = w_a_wdata_wide[j*8 +: 8];
                if (w_b_wr_bytes[j]) w_b_rd_word[j*8 +: 8] = b_wdata[j*8 +: 8];
            end
        end
        w_a_rd = '0;
        for (int l = 0; l < RATIO; l++) begin
            if (w_a_lane == c_lane_w'(l)) begin
                w_a_rd = w_a_rd_word[l*DATA_WIDTH_A +: DATA_WIDTH_A];
            end
        end
    end

    assign w_same_word = a_en & b_en & (w_a_word == b_addr);
    assign w_a_wr_any  = |w_a_wr_bytes;
    assign w_b_wr_any  = |w_b_wr_bytes;

    // Port B always touches the whole word, so any A write into it overlaps
    always_comb begin
        w_coll = 1'b0;
        if (w_same_word) begin
            if (w_a_wr_any && w_b_wr_any) begin
                w_coll = |(w_a_wr_bytes & w_b_wr_bytes);
            end else if (w_b_wr_any) begin
                w_coll = |(w_b_wr_bytes & w_a_lane_mask);
            end else begin
                w_coll = w_a_wr_any;
            end
        end
    end

    // B writes are issued last so B wins on overlapping bytes
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int j = 0; j < BE_B; j++) begin
                if (w_a_wr_bytes[j]) r_mem[w_a_word][j*8 +: 8] <= w_a_wdata_wide[j*8 +: 8];
            end
            for (int j = 0; j < BE_B; j++) begin
                if (w_b_wr_bytes[j]) r_mem[b_addr][j*8 +: 8] <= b_wdata[j*8 +: 8];
            end
        end
    end

    logic                    r_a_rvalid1;
    logic [DATA_WIDTH_A-1:0] r_a_rdata1;
    logic                    r_b_rvalid1;
    logic [DATA_WIDTH_B-1:0] r_b_rdata1;
    logic                    r_coll;
    logic [15:0]             r_coll_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_rvalid1 <= 1'b0;
            r_a_rdata1  <= '0;
            r_b_rvalid1 <= 1'b0;
            r_b_rdata1  <= '0;
            r_coll      <= 1'b0;
            r_coll_cnt  <= '0;
        end else begin
            r_a_rvalid1 <= a_en;
            r_b_rvalid1 <= b_en;
            if (a_en) r_a_rdata1 <= w_a_rd;
            if (b_en) r_b_rdata1 <= w_b_rd_word;
            r_coll <= w_coll;
            if (w_coll && (r_coll_cnt != 16'hFFFF)) r_coll_cnt <= r_coll_cnt + 16'd1;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                    r_a_rvalid2;
            logic [DATA_WIDTH_A-1:0] r_a_rdata2;
            logic                    r_b_rvalid2;
            logic [DATA_WIDTH_B-1:0] r_b_rdata2;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a_rvalid2 <= 1'b0;
                    r_a_rdata2  <= '0;
                    r_b_rvalid2 <= 1'b0;
                    r_b_rdata2  <= '0;
                end else begin
                    r_a_rvalid2 <= r_a_rvalid1;
                    r_b_rvalid2 <= r_b_rvalid1;
                    if (r_a_rvalid1) r_a_rdata2 <= r_a_rdata1;
                    if (r_b_rvalid1) r_b_rdata2 <= r_b_rdata1;
                end
            end

            assign a_rvalid = r_a_rvalid2;
            assign a_rdata  = r_a_rdata2;
            assign b_rvalid = r_b_rvalid2;
            assign b_rdata  = r_b_rdata2;
        end else begin : g_no_out_reg
            assign a_rvalid = r_a_rvalid1;
            assign a_rdata  = r_a_rdata1;
            assign b_rvalid = r_b_rvalid1;
            assign b_rdata  = r_b_rdata1;
        end
    endgenerate

    assign coll     = r_coll;
    assign coll_cnt = r_coll_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mixed_width_tdp_ram_be.sv
`default_nettype none
// ============================================================================
// Module  : tb_mixed_width_tdp_ram_be
// Brief   : Bench for mixed_width_tdp_ram_be; three parameter variants share
//           one stimulus stream and a byte-array reference model.
// Revision: 1.0
// ============================================================================
module tb_mixed_width_tdp_ram_be;

    localparam int NI = 3;  // 0: OUT_REG0/RDW0, 1: OUT_REG1/RDW1, 2: OUT_REG1/RDW0

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_en, a_we;
    logic [0:0]  a_be;
    logic [9:0]  a_addr;
    logic [7:0]  a_wdata;
    logic        b_en, b_we;
    logic [3:0]  b_be;
    logic [7:0]  b_addr;
    logic [31:0] b_wdata;

    logic [7:0]  a_rdata  [NI];
    logic        a_rvalid [NI];
    logic [31:0] b_rdata  [NI];
    logic        b_rvalid [NI];
    logic        coll     [NI];
    logic [15:0] coll_cnt [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        mixed_width_tdp_ram_be #(
            .DATA_WIDTH_A(8),
            .ADDR_WIDTH_A(10),
            .ADDR_WIDTH_B(8),
            .OUT_REG((gi == 0) ? 0 : 1),
            .RDW_MODE((gi == 1) ? 1 : 0),
            .INIT_FILE("")
        ) u_dut (
            .clk(clk), .rst(rst),
            .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr),
            .a_wdata(a_wdata), .a_rdata(a_rdata[gi]), .a_rvalid(a_rvalid[gi]),
            .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr),
            .b_wdata(b_wdata), .b_rdata(b_rdata[gi]), .b_rvalid(b_rvalid[gi]),
            .coll(coll[gi]), .coll_cnt(coll_cnt[gi])
        );
    end

    // Reference model: memory as a flat byte array, byte index = narrow address
    logic [7:0]  mem_m [1024];
    logic [7:0]  exp_a_d [NI];
    logic        exp_a_v [NI];
    logic [31:0] exp_b_d [NI];
    logic        exp_b_v [NI];
    logic        pa_v [NI];
    logic [7:0]  pa_d [NI];
    logic        pb_v [NI];
    logic [31:0] pb_d [NI];
    logic        exp_coll;
    int          exp_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            exp_a_d[i] = '0; exp_a_v[i] = 1'b0; exp_b_d[i] = '0; exp_b_v[i] = 1'b0;
            pa_v[i] = 1'b0; pa_d[i] = '0; pb_v[i] = 1'b0; pb_d[i] = '0;
        end
        exp_coll = 1'b0;
        exp_cnt  = 0;
    endtask

    task automatic idle_inputs();
        a_en = 1'b0; a_we = 1'b0; a_be = 1'b0; a_addr = '0; a_wdata = '0;
        b_en = 1'b0; b_we = 1'b0; b_be = '0;   b_addr = '0; b_wdata = '0;
    endtask

    task automatic drive_a(input logic we, input logic be, input int addr, input logic [7:0] d);
        a_en = 1'b1; a_we = we; a_be = be; a_addr = 10'(addr); a_wdata = d;
    endtask

    task automatic drive_b(input logic we, input logic [3:0] be, input int addr, input logic [31:0] d);
        b_en = 1'b1; b_we = we; b_be = be; b_addr = 8'(addr); b_wdata = d;
    endtask

    // Predict the outcome of the access currently on the inputs, then clock it
    task automatic model_step();
        logic        a_wr, b_wr, same, rdw;
        int          lane, wa;
        logic [7:0]  ra;
        logic [31:0] rb;
        wa   = int'(a_addr) / 4;
        lane = int'(a_addr) % 4;
        a_wr = a_en && a_we && a_be[0];
        b_wr = b_en && b_we && (b_be != 4'd0);
        same = a_en && b_en && (wa == int'(b_addr));
        if (!same)     exp_coll = 1'b0;
        else if (b_wr) exp_coll = b_be[lane];
        else           exp_coll = a_wr;
        if (exp_coll && exp_cnt < 65535) exp_cnt++;
        for (int i = 0; i < NI; i++) begin
            rdw = (i == 1);
            ra  = (rdw && a_wr) ? a_wdata : mem_m[a_addr];
            for (int j = 0; j < 4; j++) begin
                rb[j*8 +: 8] = (rdw && b_en && b_we && b_be[j]) ? b_wdata[j*8 +: 8]
                                                               : mem_m[int'(b_addr)*4 + j];
            end
            if (i == 0) begin
                exp_a_v[i] = a_en;
                if (a_en) exp_a_d[i] = ra;
                exp_b_v[i] = b_en;
                if (b_en) exp_b_d[i] = rb;
            end else begin
                exp_a_v[i] = pa_v[i];
                if (pa_v[i]) exp_a_d[i] = pa_d[i];
                exp_b_v[i] = pb_v[i];
                if (pb_v[i]) exp_b_d[i] = pb_d[i];
                pa_v[i] = a_en;
                if (a_en) pa_d[i] = ra;
                pb_v[i] = b_en;
                if (b_en) pb_d[i] = rb;
            end
        end
        if (a_wr) mem_m[a_addr] = a_wdata;
        for (int j = 0; j < 4; j++) begin
            if (b_en && b_we && b_be[j]) mem_m[int'(b_addr)*4 + j] = b_wdata[j*8 +: 8];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (a_rdata[i] !== 8'h0 || a_rvalid[i] !== 1'b0 || b_rdata[i] !== 32'h0 ||
                b_rvalid[i] !== 1'b0 || coll[i] !== 1'b0 || coll_cnt[i] !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_state inst%0d: a=%h/%b b=%h/%b coll=%b cnt=%0d, want all zero",
                         i, a_rdata[i], a_rvalid[i], b_rdata[i], b_rvalid[i], coll[i], coll_cnt[i]);
            end
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic init_memory();
        for (int w = 0; w < 256; w++) begin
            idle_inputs();
            drive_b(1'b1, 4'hF, w, $urandom);
            model_step();
        end
        idle_inputs();
    endtask

    task automatic test_basic_read();
        logic [31:0] pat;
        pat = 32'hDDCCBBAA;
        idle_inputs();
        drive_b(1'b1, 4'hF, 5, pat);
        model_step();
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            drive_a(1'b0, 1'b0, 20 + i, 8'h00);
            model_step();
            n_checks++;
            if (a_rvalid[0] !== 1'b1 || a_rdata[0] !== pat[i*8 +: 8]) begin
                n_fail++;
                $display("FAIL basic_read addr%0d: got %h/%b, want %h/1", 20 + i, a_rdata[0], a_rvalid[0], pat[i*8 +: 8]);
            end
        end
        idle_inputs();
        model_step();
        n_checks++;
        if (a_rvalid[0] !== 1'b0 || a_rdata[0] !== 8'hDD) begin
            n_fail++;
            $display("FAIL idle_hold: got %h/%b, want DD/0", a_rdata[0], a_rvalid[0]);
        end
    endtask

    task automatic test_byte_enable();
        idle_inputs(); drive_a(1'b1, 1'b1, 21, 8'h55); model_step();
        idle_inputs(); drive_b(1'b0, 4'h0, 5, 32'h0);  model_step();
        n_checks++;
        if (b_rdata[0] !== 32'hDDCC55AA || b_rvalid[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL narrow_write_merge: got %h/%b, want DDCC55AA/1", b_rdata[0], b_rvalid[0]);
        end
        idle_inputs(); drive_b(1'b1, 4'b0101, 5, 32'h11223344); model_step();
        idle_inputs(); drive_b(1'b0, 4'h0, 5, 32'h0);           model_step();
        n_checks++;
        if (b_rdata[0] !== 32'hDD225544) begin
            n_fail++;
            $display("FAIL wide_byte_enable: got %h, want DD225544", b_rdata[0]);
        end
    endtask

    task automatic test_collision();
        idle_inputs();
        drive_a(1'b1, 1'b1, 22, 8'hEE);
        drive_b(1'b1, 4'b0100, 5, 32'hFFFFFFFF);
        model_step();
        n_checks++;
        if (coll[0] !== 1'b1 || coll_cnt[0] !== 16'd1) begin
            n_fail++;
            $display("FAIL ww_collision: got coll=%b cnt=%0d, want 1/1", coll[0], coll_cnt[0]);
        end
        idle_inputs(); drive_b(1'b0, 4'h0, 5, 32'h0); model_step();
        n_checks++;
        if (coll[0] !== 1'b0 || b_rdata[0] !== 32'hDDFF5544) begin
            n_fail++;
            $display("FAIL ww_b_wins: got coll=%b word=%h, want 0/DDFF5544", coll[0], b_rdata[0]);
        end
        idle_inputs();
        drive_a(1'b0, 1'b0, 20, 8'h00);
        drive_b(1'b1, 4'b0001, 5, 32'h00000077);
        model_step();
        n_checks++;
        if (a_rdata[0] !== 8'h44 || coll[0] !== 1'b1 || coll_cnt[0] !== 16'd2) begin
            n_fail++;
            $display("FAIL rw_collision: got a=%h coll=%b cnt=%0d, want 44/1/2", a_rdata[0], coll[0], coll_cnt[0]);
        end
        idle_inputs(); drive_a(1'b0, 1'b0, 20, 8'h00); model_step();
        n_checks++;
        if (a_rdata[0] !== 8'h77 || coll[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_after: got a=%h coll=%b, want 77/0", a_rdata[0], coll[0]);
        end
    endtask

    task automatic test_rdw_outreg();
        idle_inputs(); drive_b(1'b1, 4'hF, 9, 32'h13579BDF); model_step();
        idle_inputs(); model_step(); model_step();
        drive_b(1'b1, 4'hF, 9, 32'hCAFEBABE); model_step();
        n_checks++;
        if (b_rvalid[1] !== 1'b0 || b_rvalid[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL outreg_latency_early: got v1=%b v2=%b, want 0/0", b_rvalid[1], b_rvalid[2]);
        end
        idle_inputs(); model_step();
        n_checks++;
        if (b_rvalid[1] !== 1'b1 || b_rdata[1] !== 32'hCAFEBABE) begin
            n_fail++;
            $display("FAIL rdw_new_data: got %h/%b, want CAFEBABE/1", b_rdata[1], b_rvalid[1]);
        end
        n_checks++;
        if (b_rvalid[2] !== 1'b1 || b_rdata[2] !== 32'h13579BDF) begin
            n_fail++;
            $display("FAIL rdw_old_data: got %h/%b, want 13579BDF/1", b_rdata[2], b_rvalid[2]);
        end
        n_checks++;
        if (b_rvalid[0] !== 1'b0 || b_rdata[0] !== 32'h13579BDF) begin
            n_fail++;
            $display("FAIL rdw_noreg_hold: got %h/%b, want 13579BDF/0", b_rdata[0], b_rvalid[0]);
        end
        model_step();
        n_checks++;
        if (b_rvalid[1] !== 1'b0 || b_rdata[1] !== 32'hCAFEBABE) begin
            n_fail++;
            $display("FAIL outreg_strobe_width: got %h/%b, want CAFEBABE/0", b_rdata[1], b_rvalid[1]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            a_en    = ($urandom_range(0, 3) != 0);
            a_we    = 1'($urandom_range(0, 1));
            a_be    = 1'($urandom_range(0, 1));
            a_addr  = ($urandom_range(0, 7) == 0) ? 10'(1020 + $urandom_range(0, 3))
                                                  : 10'($urandom_range(0, 15));
            a_wdata = 8'($urandom);
            b_en    = ($urandom_range(0, 3) != 0);
            b_we    = 1'($urandom_range(0, 1));
            b_be    = 4'($urandom);
            b_addr  = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 3));
            b_wdata = $urandom;
            model_step();
            for (int i = 0; i < NI; i++) begin
                n_checks++;
                if (a_rvalid[i] !== exp_a_v[i] || a_rdata[i] !== exp_a_d[i]) begin
                    n_fail++;
                    $display("FAIL rand_port_a inst%0d cyc%0d: got %h/%b, want %h/%b",
                             i, c, a_rdata[i], a_rvalid[i], exp_a_d[i], exp_a_v[i]);
                end
                n_checks++;
                if (b_rvalid[i] !== exp_b_v[i] || b_rdata[i] !== exp_b_d[i]) begin
                    n_fail++;
                    $display("FAIL rand_port_b inst%0d cyc%0d: got %h/%b, want %h/%b",
                             i, c, b_rdata[i], b_rvalid[i], exp_b_d[i], exp_b_v[i]);
                end
                n_checks++;
                if (coll[i] !== exp_coll || coll_cnt[i] !== 16'(exp_cnt)) begin
                    n_fail++;
                    $display("FAIL rand_collision inst%0d cyc%0d: got %b/%0d, want %b/%0d",
                             i, c, coll[i], coll_cnt[i], exp_coll, exp_cnt);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_inflight();
        idle_inputs();
        drive_a(1'b0, 1'b0, 21, 8'h00);
        drive_b(1'b0, 4'h0, 5, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (a_rdata[i] !== 8'h0 || a_rvalid[i] !== 1'b0 || b_rdata[i] !== 32'h0 ||
                b_rvalid[i] !== 1'b0 || coll[i] !== 1'b0 || coll_cnt[i] !== 16'h0) begin
                n_fail++;
                $display("FAIL async_reset inst%0d: a=%h/%b b=%h/%b coll=%b cnt=%0d, want all zero",
                         i, a_rdata[i], a_rvalid[i], b_rdata[i], b_rvalid[i], coll[i], coll_cnt[i]);
            end
        end
        idle_inputs();
        drive_b(1'b1, 4'hF, 5, 32'h0BADF00D);
        @(posedge clk);
        #1;
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            model_step();
            for (int i = 0; i < NI; i++) begin
                n_checks++;
                if (a_rvalid[i] !== 1'b0 || b_rvalid[i] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL post_reset_quiet inst%0d cyc%0d: got va=%b vb=%b, want 0/0",
                             i, k, a_rvalid[i], b_rvalid[i]);
                end
            end
        end
        drive_b(1'b0, 4'h0, 5, 32'h0);
        model_step();
        n_checks++;
        if (b_rvalid[0] !== 1'b1 || b_rdata[0] !== 32'hDDFF5577) begin
            n_fail++;
            $display("FAIL mem_preserved: got %h/%b, want DDFF5577/1", b_rdata[0], b_rvalid[0]);
        end
        idle_inputs();
        model_step();
        for (int i = 1; i < NI; i++) begin
            n_checks++;
            if (b_rvalid[i] !== 1'b1 || b_rdata[i] !== 32'hDDFF5577) begin
                n_fail++;
                $display("FAIL mem_preserved_outreg inst%0d: got %h/%b, want DDFF5577/1",
                         i, b_rdata[i], b_rvalid[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        init_memory();
        test_reset();
        test_basic_read();
        test_byte_enable();
        test_collision();
        test_rdw_outreg();
        test_random();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
